seq_adder: RTL

SEQ_ADDER -- requirements
Module: seq_adder

---
 rtl/seq_adder.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/seq_adder.sv
// rtl/seq_adder.sv - multi-cycle adder/subtractor that ripples CHUNK bits per clock
// Optional feature: define SEQ_ADDER_OVF_EN to add the signed-overflow output ovf.
module seq_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co,
`ifdef SEQ_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             busy,
  output logic             done
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({CHUNK{1'b1}});

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              c_q, c_d;
  logic [WIDTH-1:0]  s_q, s_d;
  logic              co_q, co_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef SEQ_ADDER_OVF_EN
  logic              ovf_q, ovf_d;
`endif

  logic [31:0]       base;
  logic [CHUNK-1:0]  x_sl, y_sl, sum_sl;
  logic [CHUNK:0]    cc;
  logic              last_slice;

  // One slice of full-adder cells; cc[CHUNK-1] is the carry into the slice MSB.
  always_comb begin
    base   = 32'(k_q) * CHUNK;
    x_sl   = CHUNK'(a_q >> base);
    y_sl   = CHUNK'(b_q >> base);
    sum_sl = '0;
    cc     = '0;
    cc[0]  = c_q;
    for (int i = 0; i < CHUNK; i++) begin
      sum_sl[i] = x_sl[i] ^ y_sl[i] ^ cc[i];
      cc[i+1]   = (x_sl[i] & y_sl[i]) | (y_sl[i] & cc[i]) | (cc[i] & x_sl[i]);
    end
  end

  assign last_slice = (k_q == KW'(N - 1));

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    s_d     = s_q;
    co_d    = co_q;
    busy_d  = busy_q;
    done_d  = done_q;
`ifdef SEQ_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          // Subtraction is folded into the add path as a + ~b + 1.
          a_d     = a;
          b_d     = sub ? ~b : b;
          c_d     = sub ? 1'b1 : ci;
          k_d     = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        s_d = (s_q & ~(SLICE_MASK << base)) | (WIDTH'(sum_sl) << base);
        c_d = cc[CHUNK];
        k_d = k_q + KW'(1);
        if (last_slice) begin
          co_d    = cc[CHUNK];
`ifdef SEQ_ADDER_OVF_EN
          ovf_d   = cc[CHUNK] ^ cc[CHUNK-1];
`endif
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      s_q     <= '0;
      co_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SEQ_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      s_q     <= s_d;
      co_q    <= co_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SEQ_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign s    = s_q;
  assign co   = co_q;
  assign busy = busy_q;
  assign done = done_q;
`ifdef SEQ_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule
